fifo_out_buffer_multi: RTL and testbench

// NIC output stage: parametrised successor of the single-packet output buffer. Holds up to DEPTH packets
// in a circular queue, runs VA for the oldest unallocated packet, serialises packets to flits via LA.
// Per-VC credit counters gate each flit. VA for the next packet overlaps transmission of the current one.

---
 rtl/fifo_out_buffer_multi_pkg.sv | 48 ++++
 rtl/fifo_out_buffer_multi_credit.sv | 28 ++
 rtl/fifo_out_buffer_multi.sv | 135 +++++++++++++
 tb/tb_fifo_out_buffer_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_out_buffer_multi_pkg.sv
// Shared sizing, slot-state encoding and small helpers for the multi-packet NIC output buffer.
package fifo_out_buffer_multi_pkg;

   localparam int FLIT_WIDTH  = 16;
   localparam int MAX_PKT_LEN = 5;
   localparam int DEPTH       = 4;
   localparam int N_VN        = 3;
   localparam int N_VC        = 2;
   localparam int MAX_CREDIT  = 4;

   localparam int VC_W   = N_VN * N_VC;
   localparam int VN_W   = $clog2(N_VN);
   localparam int LEN_W  = $clog2(MAX_PKT_LEN + 1);
   localparam int IDX_W  = $clog2(MAX_PKT_LEN);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int CRD_W  = $clog2(MAX_CREDIT + 1);
   localparam int PKT_W  = MAX_PKT_LEN * FLIT_WIDTH;

   typedef enum logic [1:0] {
      SLOT_EMPTY,
      SLOT_WAIT_VA,
      SLOT_ALLOC,
      SLOT_SEND
   } slot_state_t;

   // VCs owned by a virtual network sit contiguously at vn*N_VC.
   function automatic logic [VC_W-1:0] vn_mask(input logic [VN_W-1:0] vn);
      logic [VC_W-1:0] m;
      m = '0;
      for (int i = 0; i < VC_W; i++) begin
         m[i] = ((i / N_VC) == int'(vn));
      end
      return m;
   endfunction

   function automatic logic is_onehot(input logic [VC_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] raw);
      if ((raw == '0) || (raw > LEN_W'(MAX_PKT_LEN))) begin
         return LEN_W'(MAX_PKT_LEN);
      end
      return raw;
   endfunction

endpackage

// File: rtl/fifo_out_buffer_multi_credit.sv
// Per-VC downstream credit counter: loads full on reset, saturates at both ends.
module fifo_out_buffer_multi_credit
   import fifo_out_buffer_multi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic nonzero
);

   logic [CRD_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= CRD_W'(MAX_CREDIT);
      end else begin
         case ({inc, dec})
            2'b10: if (count != CRD_W'(MAX_CREDIT)) count <= count + 1'b1;
            2'b01: if (count != '0) count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign nonzero = (count != '0);

endmodule

// File: rtl/fifo_out_buffer_multi.sv
// NIC output stage: DEPTH-packet circular queue, in-order VA with one lookahead packet,
// credit-gated flit serialisation toward the router injection port.
//
// slot state   | meaning
// SLOT_EMPTY   | free for enqueue
// SLOT_WAIT_VA | packet stored, no VC yet
// SLOT_ALLOC   | VC granted, no flit sent yet
// SLOT_SEND    | at least one flit sent, tail pending
module fifo_out_buffer_multi
   import fifo_out_buffer_multi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PKT_W-1:0]      pkt_i,
   input  logic [VN_W-1:0]       vnet_id_i,
   input  logic                  is_valid_i,
   output logic                  free_slot_o,
   output logic                  r_va_o,
   output logic [VN_W-1:0]       vnet_id_o,
   input  logic                  g_va_i,
   input  logic [VC_W-1:0]       vc_id_i,
   output logic                  r_la_o,
   input  logic                  g_la_i,
   output logic [FLIT_WIDTH-1:0] flit_o,
   output logic                  is_valid_o,
   input  logic [VC_W-1:0]       credit_in_i,
   output logic                  release_pointer_o,
   output logic [VC_W-1:0]       vc_id_o
);

   logic [PKT_W-1:0]   slot_pkt [DEPTH];
   logic [VN_W-1:0]    slot_vn  [DEPTH];
   logic [LEN_W-1:0]   slot_len [DEPTH];
   logic [VC_W-1:0]    slot_vc  [DEPTH];
   slot_state_t        slot_st  [DEPTH];

   logic [PTR_W-1:0]   rd_ptr, wr_ptr, nxt_ptr, va_idx;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   flit_idx;
   logic [FLIT_WIDTH-1:0] cur_flit;
   logic [VC_W-1:0]    crd_nz, crd_dec;

   logic head_active, va_valid, va_fire, la_fire, last_flit, la_last, enq;

   assign nxt_ptr     = rd_ptr + 1'b1;
   assign free_slot_o = (cnt != CNT_W'(DEPTH));
   assign enq         = is_valid_i && free_slot_o;
   assign head_active = (slot_st[rd_ptr] == SLOT_ALLOC) || (slot_st[rd_ptr] == SLOT_SEND);

   // Lookahead VA only once the head has started sending, so at most one slot sits in ALLOC.
   always_comb begin
      va_valid = 1'b0;
      va_idx   = rd_ptr;
      if (slot_st[rd_ptr] == SLOT_WAIT_VA) begin
         va_valid = 1'b1;
      end else if ((slot_st[rd_ptr] == SLOT_SEND) && (slot_st[nxt_ptr] == SLOT_WAIT_VA)) begin
         va_valid = 1'b1;
         va_idx   = nxt_ptr;
      end
   end

   assign r_va_o    = va_valid;
   assign vnet_id_o = va_valid ? slot_vn[va_idx] : '0;
   assign va_fire   = g_va_i && va_valid && is_onehot(vc_id_i)
                      && ((vc_id_i & ~vn_mask(slot_vn[va_idx])) == '0);

   assign r_la_o    = head_active && ((slot_vc[rd_ptr] & crd_nz) != '0);
   assign la_fire   = g_la_i && r_la_o;
   assign last_flit = ((LEN_W'(flit_idx) + LEN_W'(1)) == slot_len[rd_ptr]);
   assign la_last   = la_fire && last_flit;
   assign crd_dec   = la_fire ? slot_vc[rd_ptr] : '0;
   assign cur_flit  = slot_pkt[rd_ptr][int'(flit_idx)*FLIT_WIDTH +: FLIT_WIDTH];

   for (genvar v = 0; v < VC_W; v++) begin : g_crd
      fifo_out_buffer_multi_credit u_crd (
         .clk     (clk),
         .rst     (rst),
         .inc     (credit_in_i[v]),
         .dec     (crd_dec[v]),
         .nonzero (crd_nz[v])
      );
   end

   // Payload storage carries no reset; slot_st decides whether it is meaningful.
   always_ff @(posedge clk) begin
      if (enq) begin
         slot_pkt[wr_ptr] <= pkt_i;
         slot_vn[wr_ptr]  <= vnet_id_i;
         slot_len[wr_ptr] <= sat_len(pkt_i[LEN_W-1:0]);
      end
      if (va_fire) begin
         slot_vc[va_idx] <= vc_id_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_st[i] <= SLOT_EMPTY;
         end
         rd_ptr            <= '0;
         wr_ptr            <= '0;
         cnt               <= '0;
         flit_idx          <= '0;
         flit_o            <= '0;
         is_valid_o        <= 1'b0;
         release_pointer_o <= 1'b0;
         vc_id_o           <= '0;
      end else begin
         is_valid_o        <= la_fire;
         release_pointer_o <= la_last;
         if (enq) begin
            slot_st[wr_ptr] <= SLOT_WAIT_VA;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (va_fire) begin
            slot_st[va_idx] <= SLOT_ALLOC;
         end
         if (la_fire) begin
            flit_o <= cur_flit;
            if (last_flit) begin
               slot_st[rd_ptr] <= SLOT_EMPTY;
               rd_ptr          <= nxt_ptr;
               flit_idx        <= '0;
               vc_id_o         <= slot_vc[rd_ptr];
            end else begin
               slot_st[rd_ptr] <= SLOT_SEND;
               flit_idx        <= flit_idx + 1'b1;
            end
         end
         cnt <= cnt + CNT_W'(enq) - CNT_W'(la_last);
      end
   end

endmodule

// File: tb/tb_fifo_out_buffer_multi.sv
// Directed bench for fifo_out_buffer_multi with hand-computed flit sequences.
module tb_fifo_out_buffer_multi;

   logic        clk;
   logic        rst;
   logic [79:0] pkt_i;
   logic [1:0]  vnet_id_i;
   logic        is_valid_i;
   logic        free_slot_o;
   logic        r_va_o;
   logic [1:0]  vnet_id_o;
   logic        g_va_i;
   logic [5:0]  vc_id_i;
   logic        r_la_o;
   logic        g_la_i;
   logic [15:0] flit_o;
   logic        is_valid_o;
   logic [5:0]  credit_in_i;
   logic        release_pointer_o;
   logic [5:0]  vc_id_o;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_out_buffer_multi dut (
      .clk               (clk),
      .rst               (rst),
      .pkt_i             (pkt_i),
      .vnet_id_i         (vnet_id_i),
      .is_valid_i        (is_valid_i),
      .free_slot_o       (free_slot_o),
      .r_va_o            (r_va_o),
      .vnet_id_o         (vnet_id_o),
      .g_va_i            (g_va_i),
      .vc_id_i           (vc_id_i),
      .r_la_o            (r_la_o),
      .g_la_i            (g_la_i),
      .flit_o            (flit_o),
      .is_valid_o        (is_valid_o),
      .credit_in_i       (credit_in_i),
      .release_pointer_o (release_pointer_o),
      .vc_id_o           (vc_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [79:0] p, input logic [1:0] vn);
      pkt_i      = p;
      vnet_id_i  = vn;
      is_valid_i = 1'b1;
      tick();
      is_valid_i = 1'b0;
   endtask

   task automatic va_grant(input logic [5:0] vc);
      g_va_i  = 1'b1;
      vc_id_i = vc;
      tick();
      g_va_i  = 1'b0;
      vc_id_i = '0;
   endtask

   task automatic la_one(input string tag, input logic [15:0] f, input logic rel, input logic [5:0] vc);
      g_la_i = 1'b1;
      tick();
      g_la_i = 1'b0;
      chk({tag, " valid"}, is_valid_o, 1);
      chk({tag, " flit"}, flit_o, f);
      chk({tag, " release"}, release_pointer_o, rel);
      if (rel) chk({tag, " vc_id_o"}, vc_id_o, vc);
   endtask

   task automatic give_credits(input logic [5:0] vc, input int n);
      for (int k = 0; k < n; k++) begin
         credit_in_i = vc;
         tick();
         credit_in_i = '0;
      end
   endtask

   logic [15:0] drain_f [4];
   logic [5:0]  drain_vc [4];

   initial begin
      rst = 1'b0; pkt_i = '0; vnet_id_i = '0; is_valid_i = 1'b0;
      g_va_i = 1'b0; vc_id_i = '0; g_la_i = 1'b0; credit_in_i = '0;

      // reset
      tick(); tick();
      chk("rst free", free_slot_o, 1);
      chk("rst r_va", r_va_o, 0);
      chk("rst r_la", r_la_o, 0);
      chk("rst valid", is_valid_o, 0);
      chk("rst release", release_pointer_o, 0);
      chk("rst flit", flit_o, 0);
      chk("rst vc_id_o", vc_id_o, 0);
      rst = 1'b1;
      tick();

      // single 3-flit packet
      enq(80'hFFF2BBB1BBB1BBB10003, 2'd0);
      chk("t2 r_va", r_va_o, 1);
      chk("t2 vnet", vnet_id_o, 0);
      chk("t2 r_la pre", r_la_o, 0);
      va_grant(6'b000001);
      chk("t2 r_va after grant", r_va_o, 0);
      chk("t2 r_la", r_la_o, 1);
      la_one("t2 f0", 16'h0003, 1'b0, 6'b0);
      la_one("t2 f1", 16'hBBB1, 1'b0, 6'b0);
      la_one("t2 f2", 16'hBBB1, 1'b1, 6'b000001);
      chk("t2 free", free_slot_o, 1);
      chk("t2 r_la done", r_la_o, 0);
      tick();
      chk("t2 idle valid", is_valid_o, 0);
      chk("t2 idle release", release_pointer_o, 0);

      // refill VC0 (1 left) with four returns: the last must saturate
      give_credits(6'b000001, 4);

      // credit stall, length field 0 saturates to 5
      enq({16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000}, 2'd0);
      va_grant(6'b000001);
      la_one("t3 f0", 16'hA000, 1'b0, 6'b0);
      la_one("t3 f1", 16'hA001, 1'b0, 6'b0);
      la_one("t3 f2", 16'hA002, 1'b0, 6'b0);
      la_one("t3 f3", 16'hA003, 1'b0, 6'b0);
      chk("t3 stall r_la", r_la_o, 0);
      g_la_i = 1'b1;
      tick();
      g_la_i = 1'b0;
      chk("t3 stalled grant ignored", is_valid_o, 0);
      credit_in_i = 6'b000001;
      tick();
      credit_in_i = '0;
      chk("t3 r_la after credit", r_la_o, 1);
      la_one("t3 f4", 16'hA004, 1'b1, 6'b000001);

      // full queue
      for (int i = 0; i < 4; i++) begin
         enq({64'h0, 16'hC001 + 16'(i * 16)}, 2'd2);
         chk("t4 free during fill", free_slot_o, (i < 3) ? 32'd1 : 32'd0);
      end
      enq({64'h0, 16'hC041}, 2'd2);
      chk("t4 free after drop", free_slot_o, 0);
      chk("t4 r_va", r_va_o, 1);
      chk("t4 vnet", vnet_id_o, 2);
      va_grant(6'b010000);
      la_one("t4 d0", 16'hC001, 1'b1, 6'b010000);
      chk("t4 free after tail", free_slot_o, 1);
      enq({64'h0, 16'hC051}, 2'd2);
      chk("t4 free refilled", free_slot_o, 0);
      drain_f  = '{16'hC011, 16'hC021, 16'hC031, 16'hC051};
      drain_vc = '{6'b100000, 6'b010000, 6'b100000, 6'b010000};
      for (int i = 0; i < 4; i++) begin
         chk("t4 drain r_va", r_va_o, 1);
         va_grant(drain_vc[i]);
         la_one("t4 drain", drain_f[i], 1'b1, drain_vc[i]);
      end
      chk("t4 empty free", free_slot_o, 1);
      chk("t4 empty r_va", r_va_o, 0);

      // lookahead VA and illegal grants
      enq({32'h0, 16'h1112, 16'h1111, 16'h1003}, 2'd1);
      enq({48'h0, 16'h2222, 16'h2002}, 2'd1);
      chk("t5 r_va A", r_va_o, 1);
      chk("t5 vnet A", vnet_id_o, 1);
      g_va_i = 1'b1;
      vc_id_i = 6'b001100;
      tick();
      chk("t5 two-hot ignored", r_va_o, 1);
      chk("t5 two-hot r_la", r_la_o, 0);
      vc_id_i = 6'b000001;
      tick();
      chk("t5 wrong-VN ignored", r_va_o, 1);
      chk("t5 wrong-VN r_la", r_la_o, 0);
      vc_id_i = 6'b000100;
      tick();
      g_va_i = 1'b0;
      vc_id_i = '0;
      chk("t5 B blocked while A alloc", r_va_o, 0);
      chk("t5 A r_la", r_la_o, 1);
      g_la_i = 1'b1;
      tick();
      chk("t5 A f0", flit_o, 16'h1003);
      chk("t5 B r_va", r_va_o, 1);
      chk("t5 B vnet", vnet_id_o, 1);
      g_va_i = 1'b1;
      vc_id_i = 6'b001000;
      tick();
      g_va_i = 1'b0;
      vc_id_i = '0;
      chk("t5 A f1", flit_o, 16'h1111);
      chk("t5 r_va after B grant", r_va_o, 0);
      tick();
      chk("t5 A tail", flit_o, 16'h1112);
      chk("t5 A release", release_pointer_o, 1);
      chk("t5 A vc", vc_id_o, 6'b000100);
      tick();
      chk("t5 B head", flit_o, 16'h2002);
      chk("t5 B head valid", is_valid_o, 1);
      chk("t5 B head release", release_pointer_o, 0);
      tick();
      chk("t5 B tail", flit_o, 16'h2222);
      chk("t5 B release", release_pointer_o, 1);
      chk("t5 B vc", vc_id_o, 6'b001000);
      g_la_i = 1'b0;
      tick();
      chk("t5 idle valid", is_valid_o, 0);

      // reset mid-packet
      enq({16'h0, 16'h3333, 16'h3332, 16'h3331, 16'h3004}, 2'd0);
      va_grant(6'b000010);
      la_one("t6 f0", 16'h3004, 1'b0, 6'b0);
      la_one("t6 f1", 16'h3331, 1'b0, 6'b0);
      rst = 1'b0;
      tick();
      chk("t6 rst valid", is_valid_o, 0);
      chk("t6 rst release", release_pointer_o, 0);
      chk("t6 rst flit", flit_o, 0);
      chk("t6 rst vc_id_o", vc_id_o, 0);
      chk("t6 rst r_va", r_va_o, 0);
      chk("t6 rst r_la", r_la_o, 0);
      chk("t6 rst free", free_slot_o, 1);
      rst = 1'b1;
      tick();
      chk("t6 post release", release_pointer_o, 0);
      chk("t6 post r_la", r_la_o, 0);
      enq({48'h0, 16'h4441, 16'h4002}, 2'd0);
      chk("t6 new r_va", r_va_o, 1);
      va_grant(6'b000010);
      la_one("t6 new f0", 16'h4002, 1'b0, 6'b0);
      la_one("t6 new f1", 16'h4441, 1'b1, 6'b000010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
